// File: rtl/ptw_helper_pkg.sv
// rtl/ptw_helper_pkg.sv - shared types and widths for the page-table-walk helper front-end
//
// Contents:
//   ptw_state_e : walk sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   PTE_W, LEVEL_W, PF_W : widths of the helper result fields
//   SATP_W      : width of satp and of the zero-extended VPN toward the helper
//   CNT_W       : width of the wrap-around statistics counters
package ptw_helper_pkg;

  localparam int PTE_W   = 64;
  localparam int LEVEL_W = 8;
  localparam int PF_W    = 8;
  localparam int SATP_W  = 64;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ptw_state_e;

endpackage

// File: rtl/ptw_helper_frontend_rr_arbiter.sv
// rtl/ptw_helper_frontend_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  highest-priority index this cycle (held by the parent)
//   enable in  1      when low no grant is issued
//   grant  out N      one-hot grant (all zero when nothing wins)
//   index  out IDX_W  encoded index of the winner
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  localparam int SUM_W = IDX_W + 1;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic             found;
  logic [SUM_W-1:0] offset;
  logic [SUM_W-1:0] sum;

  // Rotate the request vector so that bit 0 is the client at ptr; the first
  // set bit of the rotated vector is then the offset of the winner from ptr.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> ptr);

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = SUM_W'(k);
      end
    end
  end

  // Undo the rotation: (ptr + offset) mod N without a divider.
  assign sum   = {1'b0, ptr} + offset;
  assign index = (sum >= SUM_W'(N)) ? IDX_W'(sum - SUM_W'(N)) : IDX_W'(sum);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = enable && found && (index == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ptw_helper_frontend.sv
// rtl/ptw_helper_frontend.sv - arbitrated request front-end for the DPI page-table-walk helper
//
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   req_valid/req_ready           per-client request handshake (one ready at most)
//   req_satp, req_vpn             flattened per-client satp / VPN, client i at slice i
//   flush                         abort the walk in flight, drop any pending response
//   helper_enable                 one-cycle strobe to the helper
//   helper_satp, helper_vpn       latched request toward the helper (VPN zero-extended)
//   helper_pte/level/pf           helper results, valid the cycle after the strobe
//   resp_valid/resp_ready         response handshake
//   resp_id, resp_pte, resp_level captured result tagged with the requesting client
//   resp_pf                       OR of the captured page-fault code
//   req_count, pf_count           wrap-around accepted-request / delivered-fault counters
module ptw_helper_frontend
  import ptw_helper_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int ID_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  parameter int VPN_W     = 27
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CLIENTS-1:0]       req_valid,
  output logic [N_CLIENTS-1:0]       req_ready,
  input  logic [64*N_CLIENTS-1:0]    req_satp,
  input  logic [VPN_W*N_CLIENTS-1:0] req_vpn,
  input  logic                       flush,
  output logic                       helper_enable,
  output logic [SATP_W-1:0]          helper_satp,
  output logic [SATP_W-1:0]          helper_vpn,
  input  logic [PTE_W-1:0]           helper_pte,
  input  logic [LEVEL_W-1:0]         helper_level,
  input  logic [PF_W-1:0]            helper_pf,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [PTE_W-1:0]           resp_pte,
  output logic [LEVEL_W-1:0]         resp_level,
  output logic                       resp_pf,
  output logic [CNT_W-1:0]           req_count,
  output logic [CNT_W-1:0]           pf_count
);

  ptw_state_e state_q, state_d;

  logic [ID_W-1:0]      rr_ptr_q;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      ptr_next;
  logic [N_CLIENTS-1:0] grant;
  logic                 arb_en;
  logic                 req_fire;
  logic                 resp_fire;

  logic [SATP_W-1:0]    sel_satp;
  logic [VPN_W-1:0]     sel_vpn;

  logic [SATP_W-1:0]    satp_q;
  logic [VPN_W-1:0]     vpn_q;
  logic [ID_W-1:0]      id_q;
  logic [PTE_W-1:0]     pte_q;
  logic [LEVEL_W-1:0]   level_q;
  logic                 pf_q;
  logic [CNT_W-1:0]     req_cnt_q;
  logic [CNT_W-1:0]     pf_cnt_q;

  // Requests are only offered while idle; flush wins over a same-cycle grant.
  assign arb_en = (state_q == IDLE) && !flush;

  rr_arbiter #(
    .N     (N_CLIENTS),
    .IDX_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .enable (arb_en),
    .grant  (grant),
    .index  (win_idx)
  );

  assign req_ready = grant;
  assign req_fire  = |grant;
  assign resp_fire = (state_q == RESP) && resp_ready && !flush;
  assign ptr_next  = (win_idx == ID_W'(N_CLIENTS - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    sel_satp = '0;
    sel_vpn  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        sel_satp = req_satp[64*i +: 64];
        sel_vpn  = req_vpn[VPN_W*i +: VPN_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    helper_enable = 1'b0;
    resp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) state_d = ISSUE;
      end
      ISSUE: begin
        helper_enable = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      satp_q    <= '0;
      vpn_q     <= '0;
      id_q      <= '0;
      pte_q     <= '0;
      level_q   <= '0;
      pf_q      <= 1'b0;
      req_cnt_q <= '0;
      pf_cnt_q  <= '0;
    end else begin
      if (req_fire) begin
        satp_q    <= sel_satp;
        vpn_q     <= sel_vpn;
        id_q      <= win_idx;
        rr_ptr_q  <= ptr_next;
        req_cnt_q <= req_cnt_q + CNT_W'(1);
      end
      // The helper registers its result on the enable edge, so WAIT is the
      // first cycle in which pte/level/pf belong to this walk.
      if ((state_q == WAIT) && !flush) begin
        pte_q   <= helper_pte;
        level_q <= helper_level;
        pf_q    <= |helper_pf;
      end
      if (resp_fire && pf_q) begin
        pf_cnt_q <= pf_cnt_q + CNT_W'(1);
      end
    end
  end

  assign helper_satp = satp_q;
  assign helper_vpn  = SATP_W'(vpn_q);
  assign resp_id     = id_q;
  assign resp_pte    = pte_q;
  assign resp_level  = level_q;
  assign resp_pf     = pf_q;
  assign req_count   = req_cnt_q;
  assign pf_count    = pf_cnt_q;

endmodule
